// File: rtl/ahb_read_capture.sv
// rtl/ahb_read_capture.sv - AHB read data-phase beat capture into register-file writes.
// Optional per-command byte reversal of HRDATA when AHB_RDC_BYTE_SWAP_EN is defined.
module ahb_read_capture #(
  parameter int DATA_W = 32,
  parameter int RIDX_W = 5,
  parameter int STRIDE = 4,
  parameter int LEN_W  = 5
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [RIDX_W-1:0] cmd_ridx,
  input  logic [LEN_W-1:0]  cmd_len,
`ifdef AHB_RDC_BYTE_SWAP_EN
  input  logic              swap,
`endif
  input  logic              HREADY,
  input  logic              HRESP,
  input  logic [DATA_W-1:0] HRDATA,
  output logic              wr_en,
  output logic [RIDX_W-1:0] wr_ridx,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, DATA, ABORT} state_t;

  localparam logic [RIDX_W-1:0] STEP = RIDX_W'(STRIDE);

  state_t              state_q, state_d;
  logic [RIDX_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                wr_en_q, wr_en_d;
  logic [RIDX_W-1:0]   wr_ridx_q, wr_ridx_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   beat_data;

`ifdef AHB_RDC_BYTE_SWAP_EN
  logic swap_q, swap_d;

  function automatic logic [DATA_W-1:0] byte_rev(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 8; i++) begin
      r[8*i +: 8] = d[DATA_W-8-8*i +: 8];
    end
    return r;
  endfunction

  assign beat_data = swap_q ? byte_rev(HRDATA) : HRDATA;
`else
  assign beat_data = HRDATA;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    wr_en_d   = 1'b0;
    wr_ridx_d = wr_ridx_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    err_d     = err_q;
`ifdef AHB_RDC_BYTE_SWAP_EN
    swap_d    = swap_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          idx_d   = cmd_ridx;
          len_d   = cmd_len;
          cnt_d   = '0;
          err_d   = 1'b0;
`ifdef AHB_RDC_BYTE_SWAP_EN
          swap_d  = swap;
`endif
          state_d = DATA;
        end
      end
      DATA: begin
        // An ERROR response never carries valid data, whatever HREADY says.
        if (HRESP) begin
          state_d = ABORT;
        end else if (HREADY) begin
          wr_en_d   = 1'b1;
          wr_ridx_d = idx_q;
          wr_data_d = beat_data;
          idx_d     = idx_q + STEP;
          cnt_d     = cnt_q + LEN_W'(1);
          if (cnt_q == len_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      ABORT: begin
        if (HREADY) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_ridx_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef AHB_RDC_BYTE_SWAP_EN
      swap_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      wr_en_q   <= wr_en_d;
      wr_ridx_q <= wr_ridx_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef AHB_RDC_BYTE_SWAP_EN
      swap_q    <= swap_d;
`endif
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign wr_en     = wr_en_q;
  assign wr_ridx   = wr_ridx_q;
  assign wr_data   = wr_data_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
